// File: rtl/rasterbar_pkg.sv
// Shared types, default start palette and the colour helper functions
// for the multi-bar raster generator.
package rasterbar_pkg;

  localparam int RB_CHANW   = 4;              // bits per colour channel
  localparam int RB_COLRW   = 3 * RB_CHANW;   // packed RGB width
  localparam int RB_CNTW    = 8;              // line/colour step counter width
  localparam int RB_IDXW    = 4;              // palette index width
  localparam int RB_BAR_MAX = 16;             // palette table capacity

  typedef logic [RB_COLRW-1:0] colr_t;

  typedef struct packed {
    colr_t               colr;
    logic                inc;
    logic [RB_CNTW-1:0]  cnt_line;
    logic [RB_CNTW-1:0]  cnt_colr;
    logic [RB_IDXW-1:0]  bar_idx;
  } bar_state_t;

  // Entry [0] sits in the low bits; unused entries are black.
  typedef logic [RB_BAR_MAX-1:0][RB_COLRW-1:0] start_tbl_t;

  localparam start_tbl_t START_TBL =
    {{(RB_BAR_MAX-2){12'h000}}, 12'h640, 12'h126};

  // Move every channel one step up or down, clamping each channel on its
  // own so a saturated channel never borrows from or carries into another.
  function automatic colr_t colr_step(colr_t c, logic up);
    colr_t r;
    r = c;
    for (int i = 0; i < 3; i++) begin
      logic [RB_CHANW-1:0] ch;
      ch = c[i*RB_CHANW +: RB_CHANW];
      if (up) begin
        if (ch != '1) ch = ch + 1'b1;
      end else begin
        if (ch != '0) ch = ch - 1'b1;
      end
      r[i*RB_CHANW +: RB_CHANW] = ch;
    end
    return r;
  endfunction

  // State at the very top of the pattern: first palette, ramping up.
  function automatic bar_state_t state_init(colr_t c);
    bar_state_t s;
    s.colr     = c;
    s.inc      = 1'b1;
    s.cnt_line = '0;
    s.cnt_colr = '0;
    s.bar_idx  = '0;
    return s;
  endfunction

endpackage

// File: rtl/rasterbar_step.sv
// One-line advance of the raster-bar pattern state. Purely combinational;
// used for the beam and, when scrolling, for the frame origin.
module rasterbar_step
  import rasterbar_pkg::*;
#(
  parameter int         COLR_NUM  = 10,
  parameter int         LINE_NUM  = 2,
  parameter int         BAR_NUM   = 2,
  parameter start_tbl_t START_TBL = rasterbar_pkg::START_TBL
) (
  input  bar_state_t i_st,
  output bar_state_t o_st
);

  logic [RB_IDXW-1:0] w_idx_nxt;

  // Palette index wraps after the last configured bar.
  always_comb begin
    w_idx_nxt = i_st.bar_idx + 1'b1;
    if (i_st.bar_idx == RB_IDXW'(BAR_NUM - 1)) w_idx_nxt = '0;
  end

  // Lines repeat a colour LINE_NUM times; then the colour counter moves,
  // the ramp turns at its top, and the bar changes at the bottom.
  always_comb begin
    o_st = i_st;
    if (i_st.cnt_line < RB_CNTW'(LINE_NUM - 1)) begin
      o_st.cnt_line = i_st.cnt_line + 1'b1;
    end else begin
      o_st.cnt_line = '0;
      if (i_st.cnt_colr < RB_CNTW'(COLR_NUM - 1)) begin
        o_st.cnt_colr = i_st.cnt_colr + 1'b1;
        o_st.colr     = colr_step(i_st.colr, i_st.inc);
      end else if (i_st.inc) begin
        // peak reached: hold the colour for the first step of the descent
        o_st.inc      = 1'b0;
        o_st.cnt_colr = '0;
      end else begin
        o_st.bar_idx  = w_idx_nxt;
        o_st.colr     = START_TBL[w_idx_nxt];
        o_st.inc      = 1'b1;
        o_st.cnt_colr = '0;
      end
    end
  end

endmodule

// File: rtl/rasterbar_multi.sv
// Multi-bar raster colour generator between the display timing block and
// the VGA output registers. Optional vertical scrolling is compiled in with
// the RASTERBAR_SCROLL_EN macro; the default build draws a static pattern.
module rasterbar_multi
  import rasterbar_pkg::*;
#(
  parameter int         CORDW      = 10,
  parameter int         CHANW      = 4,
  parameter int         H_RES      = 640,
  parameter int         V_RES_FULL = 525,
  parameter int         COLR_NUM   = 10,
  parameter int         LINE_NUM   = 2,
  parameter int         BAR_NUM    = 2,
  parameter int         SCROLL_DIV = 1,
  parameter start_tbl_t START_TBL  = rasterbar_pkg::START_TBL
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix,
  input  logic [CORDW-1:0]           sx,
  input  logic [CORDW-1:0]           sy,
  input  logic                       de,
  output logic [CHANW-1:0]           paint_r,
  output logic [CHANW-1:0]           paint_g,
  output logic [CHANW-1:0]           paint_b,
  output logic [$clog2(BAR_NUM):0]   bar_id
);

  localparam int BIDW = $clog2(BAR_NUM) + 1;

  bar_state_t w_init;
  bar_state_t w_origin;
  bar_state_t w_beam_nxt;
  bar_state_t r_beam;
  logic       w_line_end;
  logic       w_frame;
  logic       w_line;

  logic [CHANW-1:0] r_paint_r, r_paint_g, r_paint_b;
  logic [BIDW-1:0]  r_bar_id;

  assign w_init = state_init(START_TBL[0]);

  // Both events fire in horizontal blanking just past the active width;
  // the last line of the frame reloads instead of stepping.
  assign w_line_end = (sx == CORDW'(H_RES));
  assign w_frame    = w_line_end && (sy == CORDW'(V_RES_FULL - 1));
  assign w_line     = w_line_end && !w_frame;

  rasterbar_step #(
    .COLR_NUM  (COLR_NUM),
    .LINE_NUM  (LINE_NUM),
    .BAR_NUM   (BAR_NUM),
    .START_TBL (START_TBL)
  ) u_step_beam (
    .i_st (r_beam),
    .o_st (w_beam_nxt)
  );

`ifdef RASTERBAR_SCROLL_EN
  localparam int DIVW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  bar_state_t       r_origin;
  bar_state_t       w_origin_nxt;
  logic [DIVW-1:0]  r_div;

  rasterbar_step #(
    .COLR_NUM  (COLR_NUM),
    .LINE_NUM  (LINE_NUM),
    .BAR_NUM   (BAR_NUM),
    .START_TBL (START_TBL)
  ) u_step_origin (
    .i_st (r_origin),
    .o_st (w_origin_nxt)
  );

  // Origin advances one line every SCROLL_DIV frames; the beam picks up the
  // pre-advance origin, so the shift shows from the following frame.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_origin <= w_init;
      r_div    <= '0;
    end else if (w_frame) begin
      if (r_div == '0) r_origin <= w_origin_nxt;
      r_div <= (r_div == DIVW'(SCROLL_DIV - 1)) ? '0 : r_div + 1'b1;
    end
  end

  assign w_origin = r_origin;
`else
  logic w_unused_scroll;

  assign w_origin        = w_init;
  assign w_unused_scroll = (SCROLL_DIV != 0);
`endif

  // Beam state: reload at frame start, step once per line.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_beam <= w_init;
    end else if (w_frame) begin
      r_beam <= w_origin;
    end else if (w_line) begin
      r_beam <= w_beam_nxt;
    end
  end

  // Output register: blank outside the active area, report the palette.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_paint_r <= '0;
      r_paint_g <= '0;
      r_paint_b <= '0;
      r_bar_id  <= '0;
    end else begin
      r_paint_r <= de ? r_beam.colr[3*CHANW-1 -: CHANW] : '0;
      r_paint_g <= de ? r_beam.colr[2*CHANW-1 -: CHANW] : '0;
      r_paint_b <= de ? r_beam.colr[CHANW-1:0]          : '0;
      r_bar_id  <= r_beam.bar_idx[BIDW-1:0];
    end
  end

  assign paint_r = r_paint_r;
  assign paint_g = r_paint_g;
  assign paint_b = r_paint_b;
  assign bar_id  = r_bar_id;

endmodule
